fwrisc_csr_seq: RTL and testbench
=================================

Name: fwrisc_csr_seq

Overview:
- Initiator side of the register-file CSR port.
- Accepts one decoded Zicsr instruction (CSRRW/CSRRS/CSRRC, register or immediate form) and maps the 12-bit CSR number onto the 6-bit register-file index space.
- Sequences the read / modify / write cycles over the single register-file read port and single write port.
- Sits between the decode stage and the register file; the core stalls on it until `done`.

Parameters:
- ENABLE_COUNTERS, 1: when 0, mcycle/mcycleh/minstret/minstreth are unmapped and therefore illegal.
- ENABLE_DEP, 1: when 0, the DEP_LO/DEP_HI CSRs are unmapped and therefore illegal.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle; handshake occurs when req_valid && req_ready
- req_op  in  2  01=RW, 10=RS, 11=RC, 00=illegal
- req_imm  in  1  source is req_zimm (zero-extended) instead of rs1 contents
- req_csr  in  12  CSR number
- req_rs1  in  5  source GPR index
- req_zimm  in  5  immediate source
- req_rd  in  5  destination GPR index
- rf_raddr  out  6  register-file read address; data returns one cycle later
- rf_rdata  in  32  register-file read data
- rf_waddr  out  6  register-file write address
- rf_wdata  out  32  register-file write data
- rf_wen  out  1  register-file write enable
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle pulse coincident with done; instruction rejected

Behaviour:
- Reset (async assert, sync release): state=IDLE, req_ready=1, rf_wen=0, rf_raddr=0, rf_waddr=0, rf_wdata=0, done=0, illegal=0, all captured operands cleared.
- Reset mid-operation aborts immediately. rf_wen drops without waiting for a clock edge, and no partial write completes.
- CSR mapping uses the shared CSR_* index constants: mstatus, mie, mtvec, mip, mhartid, mcycle(h), minstret(h), DEP_LO/HI, soft-reset.
- Any other req_csr is unmapped.
- Source value: `src` = req_imm ? {27'b0, req_zimm} : contents of req_rs1.
- Write suppression: `wr_csr` = (op==RW) || (source index != 0), where source index is req_zimm or req_rs1. RS/RC with a zero source performs no CSR write.
- Read-only CSRs: csr[11:10]==2'b11, plus mhartid and mip.
- Illegal at handshake when any of:
  - op==00;
  - CSR is unmapped;
  - wr_csr is true and the CSR is read-only.
- On an illegal request: IDLE→DONE directly, no rf_raddr change, no rf_wen.
- FSM states: IDLE, RCSR, RRS1, CALC, WCSR, WRD, DONE. Each state lasts one cycle; the handshake cycle is cycle 0.
  - RCSR (cycle 1): rf_raddr = CSR index.
  - RRS1 (cycle 2): rf_raddr = {1'b0, req_rs1}; capture old = rf_rdata. Always visited, even when req_imm=1, so latency stays fixed.
  - CALC (cycle 3): capture rs1 value; compute new value:
    - RW: src
    - RS: old | src
    - RC: old & ~src
  - WCSR: rf_wen=1, rf_waddr = CSR index, rf_wdata = new value. Skipped when !wr_csr.
  - WRD: rf_wen=1, rf_waddr = {1'b0, req_rd}, rf_wdata = old. Skipped when req_rd==0.
  - DONE: done=1 (illegal=1 if rejected), req_ready=0; next state IDLE.
- Done latency:
  - cycle 6 when both writes occur;
  - cycle 5 when exactly one write occurs;
  - cycle 4 when neither occurs;
  - cycle 1 when illegal.
- req_ready=1 only in IDLE. Back-to-back requests: a new handshake is possible the cycle after DONE.
- Request fields are registered at the handshake. Input changes afterwards are ignored.
- CSR write precedes rd write. Both reads complete before any write, so rd==rs1 is safe.
- rf_wen is never asserted for index 0. The soft-reset CSR is writable through WCSR like any other mapped CSR.

Test Plan:
- Reset, then CSRRW mtvec, rs1=x5=0x8000_0100, rd=x6, old mtvec=0 -> cycle 4 writes mtvec←0x80000100; cycle 5 writes x6←0; done at cycle 6; illegal=0.
- CSRRS mstatus, rs1=x0, rd=x7, mstatus reads 0x88 -> no CSR write; cycle 4 writes x7←0x88; done at cycle 5.
- CSRRCI mie, zimm=0x1F, rd=x0, old mie=0x0000_0800 -> CSR write 0x0000_0800 (bits 4:0 cleared, none set); no rd write; done at cycle 5.
- CSRRW mhartid (write to read-only) and req_csr=0x7C0 (unmapped) -> done+illegal at cycle 1; rf_wen never asserted; rf_raddr unchanged.
- ENABLE_COUNTERS=0: CSRRS mcycle with rs1=x0 -> illegal. ENABLE_COUNTERS=1: same request -> rd gets rf_rdata latched in RRS1.
- Reset asserted at cycle 4 of a full RW (rf_wen=1) -> rf_wen=0 and req_ready=1 immediately; next request completes normally with correct latency.

Source files
------------

// File: rtl/fwrisc_csr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fwrisc_csr_seq
//  Purpose  : Initiator side of the register-file CSR port. Accepts one
//             decoded Zicsr instruction (CSRRW/CSRRS/CSRRC, register or
//             immediate form), maps the 12-bit CSR number onto the 6-bit
//             register-file index space, and sequences the read / modify /
//             write cycles over a single read port and a single write port.
//  Ports    : clock, reset (async, active-low)
//             req_valid/req_ready        request handshake
//             req_op/imm/csr/rs1/zimm/rd request fields, registered at handshake
//             rf_raddr / rf_rdata        register-file read port (1-cycle latency)
//             rf_waddr/rf_wdata/rf_wen   register-file write port
//             done / illegal             one-cycle completion pulses
//  Revision : 1.0  initial release
// ============================================================================
module fwrisc_csr_seq #(
  parameter int unsigned ENABLE_COUNTERS = 1,
  parameter int unsigned ENABLE_DEP      = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_imm,
  input  logic [11:0] req_csr,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_zimm,
  input  logic [4:0]  req_rd,
  output logic [5:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_wen,
  output logic        done,
  output logic        illegal
);

  // CSR slots in the upper half of the register file (GPRs occupy 0..31).
  localparam logic [5:0] CSR_MSTATUS   = 6'h20;
  localparam logic [5:0] CSR_MIE       = 6'h21;
  localparam logic [5:0] CSR_MTVEC     = 6'h22;
  localparam logic [5:0] CSR_MIP       = 6'h23;
  localparam logic [5:0] CSR_MHARTID   = 6'h24;
  localparam logic [5:0] CSR_MCYCLE    = 6'h25;
  localparam logic [5:0] CSR_MCYCLEH   = 6'h26;
  localparam logic [5:0] CSR_MINSTRET  = 6'h27;
  localparam logic [5:0] CSR_MINSTRETH = 6'h28;
  localparam logic [5:0] CSR_DEP_LO    = 6'h29;
  localparam logic [5:0] CSR_DEP_HI    = 6'h2A;
  localparam logic [5:0] CSR_SOFT_RST  = 6'h2B;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic COUNTERS_ON = (ENABLE_COUNTERS != 0);
  localparam logic DEP_ON      = (ENABLE_DEP != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RCSR = 3'd1,
    S_RRS1 = 3'd2,
    S_CALC = 3'd3,
    S_WCSR = 3'd4,
    S_WRD  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        imm_q, imm_d;
  logic [4:0]  zimm_q, zimm_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rd_q, rd_d;
  logic [5:0]  idx_q, idx_d;
  logic        wr_csr_q, wr_csr_d;
  logic        illegal_q, illegal_d;
  logic [31:0] old_q, old_d;
  logic [31:0] new_q, new_d;
  logic [5:0]  raddr_q, raddr_d;

  // Handshake-time decode of the incoming request.
  logic [5:0]  map_idx;
  logic        map_ok;
  logic        map_ro;
  logic [4:0]  src_idx;
  logic        wr_csr;
  logic        req_bad;
  logic        hs;
  logic [31:0] src_val;

  always_comb begin
    map_idx = 6'd0;
    map_ok  = 1'b0;
    case (req_csr)
      12'h300: begin map_idx = CSR_MSTATUS;   map_ok = 1'b1;        end
      12'h304: begin map_idx = CSR_MIE;       map_ok = 1'b1;        end
      12'h305: begin map_idx = CSR_MTVEC;     map_ok = 1'b1;        end
      12'h344: begin map_idx = CSR_MIP;       map_ok = 1'b1;        end
      12'hF14: begin map_idx = CSR_MHARTID;   map_ok = 1'b1;        end
      12'hB00: begin map_idx = CSR_MCYCLE;    map_ok = COUNTERS_ON; end
      12'hB80: begin map_idx = CSR_MCYCLEH;   map_ok = COUNTERS_ON; end
      12'hB02: begin map_idx = CSR_MINSTRET;  map_ok = COUNTERS_ON; end
      12'hB82: begin map_idx = CSR_MINSTRETH; map_ok = COUNTERS_ON; end
      12'hBC0: begin map_idx = CSR_DEP_LO;    map_ok = DEP_ON;      end
      12'hBC1: begin map_idx = CSR_DEP_HI;    map_ok = DEP_ON;      end
      12'hBC2: begin map_idx = CSR_SOFT_RST;  map_ok = 1'b1;        end
      default: begin map_idx = 6'd0;          map_ok = 1'b0;        end
    endcase
  end

  assign map_ro  = (req_csr[11:10] == 2'b11) || (map_idx == CSR_MHARTID) ||
                   (map_idx == CSR_MIP);
  assign src_idx = req_imm ? req_zimm : req_rs1;
  // RS/RC with a zero source is a pure read and must not write the CSR.
  assign wr_csr  = (req_op == OP_RW) || (src_idx != 5'd0);
  assign req_bad = (req_op == 2'b00) || !map_ok || (wr_csr && map_ro);
  assign hs      = req_valid && (state_q == S_IDLE);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    imm_d     = imm_q;
    zimm_d    = zimm_q;
    rs1_d     = rs1_q;
    rd_d      = rd_q;
    idx_d     = idx_q;
    wr_csr_d  = wr_csr_q;
    illegal_d = illegal_q;
    old_d     = old_q;
    new_d     = new_q;
    raddr_d   = raddr_q;
    src_val   = 32'd0;
    req_ready = 1'b0;
    rf_wen    = 1'b0;
    rf_waddr  = 6'd0;
    rf_wdata  = 32'd0;
    done      = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (hs) begin
          op_d      = req_op;
          imm_d     = req_imm;
          zimm_d    = req_zimm;
          rs1_d     = req_rs1;
          rd_d      = req_rd;
          idx_d     = map_idx;
          wr_csr_d  = wr_csr;
          illegal_d = req_bad;
          if (req_bad) begin
            // Rejected requests leave the read port untouched.
            state_d = S_DONE;
          end else begin
            raddr_d = map_idx;
            state_d = S_RCSR;
          end
        end
      end
      S_RCSR: begin
        raddr_d = {1'b0, rs1_q};
        state_d = S_RRS1;
      end
      S_RRS1: begin
        // CSR read data returns this cycle. rs1 is read even for the
        // immediate form so the latency does not depend on the source.
        old_d   = rf_rdata;
        state_d = S_CALC;
      end
      S_CALC: begin
        src_val = imm_q ? {27'd0, zimm_q} : rf_rdata;
        case (op_q)
          OP_RS:   new_d = old_q | src_val;
          OP_RC:   new_d = old_q & ~src_val;
          default: new_d = src_val;
        endcase
        if (wr_csr_q)           state_d = S_WCSR;
        else if (rd_q != 5'd0)  state_d = S_WRD;
        else                    state_d = S_DONE;
      end
      S_WCSR: begin
        rf_wen   = 1'b1;
        rf_waddr = idx_q;
        rf_wdata = new_q;
        state_d  = (rd_q != 5'd0) ? S_WRD : S_DONE;
      end
      S_WRD: begin
        rf_wen   = 1'b1;
        rf_waddr = {1'b0, rd_q};
        rf_wdata = old_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        illegal = illegal_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rf_raddr = raddr_q;

  // Write-port outputs decode from state_q, so an asynchronous reset drops
  // rf_wen immediately without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= 2'd0;
      imm_q     <= 1'b0;
      zimm_q    <= 5'd0;
      rs1_q     <= 5'd0;
      rd_q      <= 5'd0;
      idx_q     <= 6'd0;
      wr_csr_q  <= 1'b0;
      illegal_q <= 1'b0;
      old_q     <= 32'd0;
      new_q     <= 32'd0;
      raddr_q   <= 6'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      zimm_q    <= zimm_d;
      rs1_q     <= rs1_d;
      rd_q      <= rd_d;
      idx_q     <= idx_d;
      wr_csr_q  <= wr_csr_d;
      illegal_q <= illegal_d;
      old_q     <= old_d;
      new_q     <= new_d;
      raddr_q   <= raddr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fwrisc_csr_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fwrisc_csr_seq
//  Purpose  : Bench for fwrisc_csr_seq. A behavioural register file serves
//             the read/write ports; expected writes and completions are
//             queued at request time and compared as the DUT produces them.
//             A second instance with counters disabled checks the mcycle
//             rejection path.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fwrisc_csr_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_imm;
  logic [11:0] req_csr;
  logic [4:0]  req_rs1;
  logic [4:0]  req_zimm;
  logic [4:0]  req_rd;
  logic [5:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wen;
  logic        done;
  logic        illegal;

  logic        nc_ready;
  logic [5:0]  nc_raddr;
  logic [31:0] nc_rdata = 32'd0;
  logic [5:0]  nc_waddr;
  logic [31:0] nc_wdata;
  logic        nc_wen;
  logic        nc_done;
  logic        nc_illegal;

  always #5 clock = ~clock;

  fwrisc_csr_seq #(.ENABLE_COUNTERS(1), .ENABLE_DEP(1)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_imm(req_imm), .req_csr(req_csr),
    .req_rs1(req_rs1), .req_zimm(req_zimm), .req_rd(req_rd),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .done(done), .illegal(illegal)
  );

  fwrisc_csr_seq #(.ENABLE_COUNTERS(0), .ENABLE_DEP(1)) u_nc (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(nc_ready),
    .req_op(req_op), .req_imm(req_imm), .req_csr(req_csr),
    .req_rs1(req_rs1), .req_zimm(req_zimm), .req_rd(req_rd),
    .rf_raddr(nc_raddr), .rf_rdata(nc_rdata),
    .rf_waddr(nc_waddr), .rf_wdata(nc_wdata), .rf_wen(nc_wen),
    .done(nc_done), .illegal(nc_illegal)
  );

  // Register-file indices used by the bench.
  localparam logic [5:0] I_MSTATUS = 6'h20;
  localparam logic [5:0] I_MIE     = 6'h21;
  localparam logic [5:0] I_MTVEC   = 6'h22;
  localparam logic [5:0] I_MHARTID = 6'h24;
  localparam logic [5:0] I_MCYCLE  = 6'h25;
  localparam logic [5:0] I_DEP_LO  = 6'h29;
  localparam logic [5:0] I_SOFTRST = 6'h2B;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] rf [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_a  = 6'd0;
  logic [31:0] pre_d  = 32'd0;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rf_rdata <= rf[rf_raddr];
    if (pre_we)      rf[pre_a]    <= pre_d;
    else if (rf_wen) rf[rf_waddr] <= rf_wdata;
  end

  typedef struct { logic [5:0] a; logic [31:0] d; int c; } wr_t;
  typedef struct { logic ill; int c; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: every write and completion must match the next queued one.
  always @(negedge clock) begin
    if (reset) begin
      if (rf_wen) begin
        check("wr_pending", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", 32'(rf_waddr), 32'(e.a));
          check("wr_data", rf_wdata, e.d);
          check("wr_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (done) begin
        check("done_pending", 32'(dq.size() != 0), 32'd1);
        check("done_ready", 32'(req_ready), 32'd0);
        if (dq.size() != 0) begin
          dn_t e;
          e = dq.pop_front();
          check("done_illegal", 32'(illegal), 32'(e.ill));
          check("done_cycle", 32'(cyc), 32'(e.c));
        end
      end
    end
  end

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_we = 1'b1;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  // Drive one request, queue its expected writes/completion, return the
  // handshake cycle number.
  task automatic issue(input logic [1:0] op, input logic imm, input logic [11:0] csr,
                       input logic [5:0] idx, input logic [4:0] rs1, input logic [4:0] zimm,
                       input logic [4:0] rd, input logic ill, output int hs);
    int          n;
    int          k;
    logic [31:0] src;
    logic [31:0] old;
    logic [31:0] nv;
    logic        wr;
    n = 0;
    while (!(req_ready && nc_ready) && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ready_wait", 32'(req_ready && nc_ready), 32'd1);
    src = imm ? {27'd0, zimm} : rf[{1'b0, rs1}];
    wr  = (op == 2'b01) || ((imm ? zimm : rs1) != 5'd0);
    old = rf[idx];
    case (op)
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = 32'd0;
    endcase
    hs = cyc;
    if (ill) begin
      dq.push_back('{ill: 1'b1, c: hs + 1});
    end else begin
      k = 4;
      if (wr) begin
        wq.push_back('{a: idx, d: nv, c: hs + k});
        k++;
      end
      if (rd != 5'd0) begin
        wq.push_back('{a: {1'b0, rd}, d: old, c: hs + k});
        k++;
      end
      dq.push_back('{ill: 1'b0, c: hs + k});
    end
    req_op    = op;
    req_imm   = imm;
    req_csr   = csr;
    req_rs1   = rs1;
    req_zimm  = zimm;
    req_rd    = rd;
    req_valid = 1'b1;
    @(negedge clock);
    // Scramble the fields: the DUT must work from its captured copy.
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_imm   = 1'($urandom);
    req_csr   = 12'($urandom);
    req_rs1   = 5'($urandom);
    req_zimm  = 5'($urandom);
    req_rd    = 5'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (dq.size() != 0 && n < 30) begin
      @(negedge clock);
      n++;
    end
    check("drain_done", 32'(dq.size()), 32'd0);
    check("drain_wr", 32'(wq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          hs;
    logic [5:0]  ra;
    logic [31:0] keep;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_imm   = 1'b0;
    req_csr   = 12'd0;
    req_rs1   = 5'd0;
    req_zimm  = 5'd0;
    req_rd    = 5'd0;
    @(negedge clock);
    for (int i = 0; i < 64; i++) preload(6'(i), 32'd0);
    preload(6'd5, 32'h8000_0100);
    preload(6'd9, 32'h0000_00F0);
    preload(I_MSTATUS, 32'h0000_0088);
    preload(I_MIE, 32'h0000_0800);
    preload(I_MCYCLE, 32'h1234_5678);
    preload(I_DEP_LO, 32'h0F0F_0F0F);

    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_wen", 32'(rf_wen), 32'd0);
    check("rst_raddr", 32'(rf_raddr), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // CSRRW mtvec, rs1=x5, rd=x6
    issue(2'b01, 1'b0, 12'h305, I_MTVEC, 5'd5, 5'd0, 5'd6, 1'b0, hs);
    drain();
    // CSRRS mstatus, rs1=x0, rd=x7: pure read
    issue(2'b10, 1'b0, 12'h300, I_MSTATUS, 5'd0, 5'd0, 5'd7, 1'b0, hs);
    drain();
    // CSRRCI mie, zimm=0x1F, rd=x0
    issue(2'b11, 1'b1, 12'h304, I_MIE, 5'd0, 5'h1F, 5'd0, 1'b0, hs);
    drain();
    // CSRRW mhartid: write to read-only
    ra = rf_raddr;
    issue(2'b01, 1'b0, 12'hF14, I_MHARTID, 5'd5, 5'd0, 5'd6, 1'b1, hs);
    drain();
    check("ill_raddr_ro", 32'(rf_raddr), 32'(ra));
    // Unmapped CSR number
    issue(2'b10, 1'b0, 12'h7C0, 6'd0, 5'd0, 5'd0, 5'd6, 1'b1, hs);
    drain();
    check("ill_raddr_unmapped", 32'(rf_raddr), 32'(ra));
    // op==00
    issue(2'b00, 1'b0, 12'h300, I_MSTATUS, 5'd5, 5'd0, 5'd6, 1'b1, hs);
    drain();
    // CSRRS mcycle, rs1=x0: legal with counters, illegal without
    issue(2'b10, 1'b0, 12'hB00, I_MCYCLE, 5'd0, 5'd0, 5'd8, 1'b0, hs);
    check("nc_done", 32'(nc_done), 32'd1);
    check("nc_illegal", 32'(nc_illegal), 32'd1);
    drain();
    // CSRRS mstatus with a nonzero source: both writes
    issue(2'b10, 1'b0, 12'h300, I_MSTATUS, 5'd9, 5'd0, 5'd10, 1'b0, hs);
    drain();
    // CSRRWI DEP_LO with zimm=0: RW still writes
    issue(2'b01, 1'b1, 12'hBC0, I_DEP_LO, 5'd0, 5'd0, 5'd0, 1'b0, hs);
    drain();
    // CSRRSI mstatus, zimm=0, rd=x0: no writes at all
    issue(2'b10, 1'b1, 12'h300, I_MSTATUS, 5'd0, 5'd0, 5'd0, 1'b0, hs);
    drain();
    // Soft-reset CSR is an ordinary writable CSR
    issue(2'b01, 1'b0, 12'hBC2, I_SOFTRST, 5'd5, 5'd0, 5'd0, 1'b0, hs);
    drain();
    // CSRRC mstatus with rd==rs1
    issue(2'b11, 1'b0, 12'h300, I_MSTATUS, 5'd9, 5'd0, 5'd9, 1'b0, hs);
    drain();

    // Reset during the CSR write cycle of a full RW
    keep = rf[I_MTVEC];
    issue(2'b01, 1'b0, 12'h305, I_MTVEC, 5'd9, 5'd0, 5'd6, 1'b0, hs);
    while (cyc < hs + 4) @(negedge clock);
    check("pre_rst_wen", 32'(rf_wen), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_wen", 32'(rf_wen), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd1);
    wq.delete();
    dq.delete();
    @(negedge clock);
    check("aborted_write", rf[I_MTVEC], keep);
    reset = 1'b1;
    @(negedge clock);
    // Normal request after the abort
    issue(2'b10, 1'b0, 12'h300, I_MSTATUS, 5'd0, 5'd0, 5'd11, 1'b0, hs);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
